// File: rtl/microsequencer.sv
// rtl/microsequencer.sv - microprogram sequencer: owns CAR, handles WMFC stalls/timeout, dispatch, END and HALT
module microsequencer #(
  parameter int SZ       = 24,
  parameter int N        = 7,
  parameter int OP_W     = 3,
  parameter int STRIDE   = 4,
  parameter int NUM_OPS  = 5,
  parameter int WMFC_BIT = 8,
  parameter int SEL_BIT  = 22,
  parameter int END_BIT  = SZ - 1,
  parameter int TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SZ-1:0]   CBR,
  input  logic [OP_W-1:0] opcode,
  input  logic            MFC,
  input  logic            halt,
  output logic [N-1:0]    CAR,
  output logic            stalled,
  output logic            halted,
  output logic            illegal_op,
  output logic            bus_error,
  output logic [15:0]     retired
);

  localparam int WC = $clog2(TIMEOUT + 1);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  car_q, car_d;
  logic [WC-1:0] wcnt_q, wcnt_d;
  logic          ill_q, ill_d;
  logic          bus_q, bus_d;
  logic [15:0]   ret_q, ret_d;
  logic          stall_c;
  logic          wait_miss;

  assign wait_miss = CBR[WMFC_BIT] && !MFC;

  always_comb begin
    state_d = state_q;
    car_d   = car_q;
    wcnt_d  = '0;
    ill_d   = ill_q;
    bus_d   = bus_q;
    ret_d   = ret_q;
    stall_c = 1'b0;
    case (state_q)
      S_HALT: begin
        car_d = '0;
        if (!halt) state_d = S_RUN;
      end
      default: begin
        // Priority order: stall, timeout abort, end-of-routine, dispatch, step.
        if (wait_miss && (wcnt_q < WC'(TIMEOUT))) begin
          wcnt_d  = wcnt_q + WC'(1);
          stall_c = 1'b1;
        end else if (wait_miss) begin
          car_d = '0;
          bus_d = 1'b1;
        end else if (CBR[END_BIT]) begin
          ret_d = ret_q + 16'd1;
          car_d = '0;
          if (halt) state_d = S_HALT;
        end else if (CBR[SEL_BIT]) begin
          if (int'(opcode) < NUM_OPS) begin
            car_d = N'(int'(opcode) * STRIDE);
          end else begin
            car_d = '0;
            ill_d = 1'b1;
          end
        end else begin
          car_d = car_q + N'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      car_q   <= '0;
      wcnt_q  <= '0;
      ill_q   <= 1'b0;
      bus_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      car_q   <= car_d;
      wcnt_q  <= wcnt_d;
      ill_q   <= ill_d;
      bus_q   <= bus_d;
      ret_q   <= ret_d;
    end
  end

  // stalled is combinational so it drops in the same cycle MFC arrives.
  assign CAR        = car_q;
  assign stalled    = stall_c;
  assign halted     = (state_q == S_HALT);
  assign illegal_op = ill_q;
  assign bus_error  = bus_q;
  assign retired    = ret_q;

endmodule

// File: tb/tb_microsequencer.sv
// tb/tb_microsequencer.sv - self-checking bench for microsequencer with a behavioural sequencing model
module tb_microsequencer;

  localparam int TIMEOUT = 15;
  localparam int NUM_OPS = 5;
  localparam int STRIDE  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] cbr;
  logic [2:0]  opcode = 3'd0;
  logic        mfc = 1'b1;
  logic        halt = 1'b0;
  logic [6:0]  car;
  logic        stalled, halted, illegal_op, bus_error;
  logic [15:0] retired;

  logic [23:0] cs [0:127];
  int tests = 0;
  int fails = 0;

  int m_car, m_wait, m_ret;
  bit m_halted, m_ill, m_bus;

  microsequencer dut (
    .clk(clk), .rst(rst), .CBR(cbr), .opcode(opcode), .MFC(mfc), .halt(halt),
    .CAR(car), .stalled(stalled), .halted(halted), .illegal_op(illegal_op),
    .bus_error(bus_error), .retired(retired)
  );

  always #5 clk = ~clk;
  assign cbr = cs[car];

  function automatic bit is_wmfc(int a); logic [23:0] w; w = cs[a]; return w[8];  endfunction
  function automatic bit is_sel(int a);  logic [23:0] w; w = cs[a]; return w[22]; endfunction
  function automatic bit is_end(int a);  logic [23:0] w; w = cs[a]; return w[23]; endfunction

  function automatic bit exp_stall();
    return !m_halted && is_wmfc(m_car) && !mfc && (m_wait < TIMEOUT);
  endfunction

  task automatic model_reset();
    m_car = 0; m_wait = 0; m_ret = 0; m_halted = 0; m_ill = 0; m_bus = 0;
  endtask

  // Reference: decide the next microaddress from the word at the model's address, then clock.
  task automatic advance();
    if (m_halted) begin
      m_car = 0;
      if (!halt) m_halted = 0;
    end else if (is_wmfc(m_car) && !mfc) begin
      if (m_wait < TIMEOUT) m_wait = m_wait + 1;
      else begin m_wait = 0; m_car = 0; m_bus = 1; end
    end else begin
      m_wait = 0;
      if (is_end(m_car)) begin
        m_ret = (m_ret + 1) % 65536;
        m_car = 0;
        if (halt) m_halted = 1;
      end else if (is_sel(m_car)) begin
        if (int'(opcode) < NUM_OPS) m_car = (int'(opcode) * STRIDE) % 128;
        else begin m_car = 0; m_ill = 1; end
      end else begin
        m_car = (m_car + 1) % 128;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic to_fetch();
    halt = 1'b0; mfc = 1'b1; opcode = 3'd3;
    for (int i = 0; i < 40 && m_car != 0; i++) advance();
  endtask

  task automatic test_reset();
    rst = 1'b1; mfc = 1'b1; halt = 1'b0; opcode = 3'd0;
    model_reset();
    @(posedge clk); #1; rst = 1'b0; #1;
    tests++; if (car !== 7'd0) begin fails++; $display("FAIL reset_car: got %0d expected 0", car); end
    tests++; if (stalled !== 1'b0) begin fails++; $display("FAIL reset_stalled: got %b expected 0", stalled); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b expected 0", halted); end
    tests++; if (illegal_op !== 1'b0) begin fails++; $display("FAIL reset_illegal: got %b expected 0", illegal_op); end
    tests++; if (bus_error !== 1'b0) begin fails++; $display("FAIL reset_bus_error: got %b expected 0", bus_error); end
    tests++; if (retired !== 16'd0) begin fails++; $display("FAIL reset_retired: got %0d expected 0", retired); end
  endtask

  task automatic test_fetch_load();
    int seq [8] = '{0, 1, 2, 3, 4, 5, 6, 0};
    mfc = 1'b1; opcode = 3'd1; halt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      tests++; if (car !== 7'(seq[i])) begin fails++; $display("FAIL load_seq[%0d]: got %0d expected %0d", i, car, seq[i]); end
      if (i < 7) advance();
    end
    tests++; if (retired !== 16'd1) begin fails++; $display("FAIL load_retired: got %0d expected 1", retired); end
  endtask

  task automatic test_stall();
    mfc = 1'b1; opcode = 3'd3;
    advance();
    mfc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (car !== 7'd1 || stalled !== 1'b1) begin fails++; $display("FAIL stall_hold[%0d]: got car=%0d stalled=%b expected car=1 stalled=1", i, car, stalled); end
      advance();
    end
    mfc = 1'b1; #1;
    tests++; if (car !== 7'd1 || stalled !== 1'b0) begin fails++; $display("FAIL stall_release: got car=%0d stalled=%b expected car=1 stalled=0", car, stalled); end
    advance(); #1;
    tests++; if (car !== 7'd2) begin fails++; $display("FAIL stall_next: got %0d expected 2", car); end
    to_fetch();
  endtask

  task automatic test_timeout();
    mfc = 1'b1; opcode = 3'd3;
    advance();
    mfc = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      tests++; if (car !== 7'd1 || stalled !== (i < 15)) begin fails++; $display("FAIL timeout_hold[%0d]: got car=%0d stalled=%b expected car=1 stalled=%b", i, car, stalled, i < 15); end
      advance();
    end
    #1;
    tests++; if (car !== 7'd0 || bus_error !== 1'b1) begin fails++; $display("FAIL timeout_abort: got car=%0d bus_error=%b expected car=0 bus_error=1", car, bus_error); end
    mfc = 1'b1;
    for (int i = 0; i < 20; i++) advance();
    #1;
    tests++; if (bus_error !== 1'b1 || car !== 7'(m_car)) begin fails++; $display("FAIL timeout_sticky: got car=%0d bus_error=%b expected car=%0d bus_error=1", car, bus_error, m_car); end
    to_fetch();
  endtask

  task automatic test_illegal();
    int seq [5] = '{0, 1, 2, 3, 0};
    logic [15:0] r0;
    mfc = 1'b1; opcode = 3'd7; #1;
    r0 = retired;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++; if (car !== 7'(seq[i])) begin fails++; $display("FAIL illegal_seq[%0d]: got %0d expected %0d", i, car, seq[i]); end
      if (i < 4) advance();
    end
    tests++; if (illegal_op !== 1'b1) begin fails++; $display("FAIL illegal_flag: got %b expected 1", illegal_op); end
    tests++; if (retired !== 16'(m_ret) || retired !== r0) begin fails++; $display("FAIL illegal_retired: got %0d expected %0d", retired, m_ret); end
  endtask

  task automatic test_halt();
    int seq [7] = '{0, 1, 2, 3, 8, 9, 10};
    mfc = 1'b1; opcode = 3'd2; halt = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      tests++; if (car !== 7'(seq[i]) || halted !== 1'b0) begin fails++; $display("FAIL halt_seq[%0d]: got car=%0d halted=%b expected car=%0d halted=0", i, car, halted, seq[i]); end
      advance();
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++; if (car !== 7'd0 || halted !== 1'b1) begin fails++; $display("FAIL halt_hold[%0d]: got car=%0d halted=%b expected car=0 halted=1", i, car, halted); end
      advance();
    end
    halt = 1'b0; #1;
    tests++; if (car !== 7'd0 || halted !== 1'b1) begin fails++; $display("FAIL halt_release: got car=%0d halted=%b expected car=0 halted=1", car, halted); end
    advance(); #1;
    tests++; if (car !== 7'd0 || halted !== 1'b0) begin fails++; $display("FAIL halt_resume0: got car=%0d halted=%b expected car=0 halted=0", car, halted); end
    advance(); #1;
    tests++; if (car !== 7'd1) begin fails++; $display("FAIL halt_resume1: got %0d expected 1", car); end
    to_fetch();
  endtask

  task automatic test_end_sel();
    int seq [6] = '{0, 1, 2, 3, 16, 0};
    int r0;
    mfc = 1'b1; opcode = 3'd4; halt = 1'b0;
    r0 = m_ret;
    for (int i = 0; i < 6; i++) begin
      #1;
      tests++; if (car !== 7'(seq[i])) begin fails++; $display("FAIL endsel_seq[%0d]: got %0d expected %0d", i, car, seq[i]); end
      if (i < 5) advance();
    end
    tests++; if (retired !== 16'(r0 + 1)) begin fails++; $display("FAIL endsel_retired: got %0d expected %0d", retired, r0 + 1); end
  endtask

  task automatic test_reset_mid_stall();
    mfc = 1'b1; opcode = 3'd3; halt = 1'b0;
    advance();
    mfc = 1'b0;
    advance(); #1;
    tests++; if (car !== 7'd1 || stalled !== 1'b1) begin fails++; $display("FAIL rststall_pre: got car=%0d stalled=%b expected car=1 stalled=1", car, stalled); end
    rst = 1'b1; #1;
    tests++; if (car !== 7'd0 || stalled !== 1'b0) begin fails++; $display("FAIL rststall_async: got car=%0d stalled=%b expected car=0 stalled=0", car, stalled); end
    tests++; if (illegal_op !== 1'b0 || bus_error !== 1'b0 || retired !== 16'd0) begin fails++; $display("FAIL rststall_flags: got ill=%b bus=%b ret=%0d expected 0 0 0", illegal_op, bus_error, retired); end
    model_reset();
    @(posedge clk); #1; rst = 1'b0; mfc = 1'b1;
  endtask

  task automatic test_random();
    int burst = 0;
    for (int c = 0; c < 600; c++) begin
      if (burst > 0) begin mfc = 1'b0; burst--; end
      else if ($urandom_range(0, 39) == 0) begin mfc = 1'b0; burst = $urandom_range(8, 20); end
      else mfc = ($urandom_range(0, 3) != 0);
      opcode = 3'($urandom_range(0, 7));
      halt = ($urandom_range(0, 7) == 0);
      #1;
      tests++;
      if ({car, stalled, halted, illegal_op, bus_error, retired} !==
          {7'(m_car), exp_stall(), m_halted, m_ill, m_bus, 16'(m_ret)}) begin
        fails++;
        $display("FAIL random[%0d]: got car=%0d st=%b h=%b ill=%b bus=%b ret=%0d expected car=%0d st=%b h=%b ill=%b bus=%b ret=%0d",
                 c, car, stalled, halted, illegal_op, bus_error, retired,
                 m_car, exp_stall(), m_halted, m_ill, m_bus, m_ret);
      end
      advance();
    end
  endtask

  initial begin
    for (int a = 0; a < 128; a++) cs[a] = 24'h0;
    cs[1]  = 24'h000100;
    cs[3]  = 24'h400000;
    cs[5]  = 24'h000100;
    cs[6]  = 24'h800000;
    cs[9]  = 24'h000100;
    cs[10] = 24'h800000;
    cs[13] = 24'h800000;
    cs[16] = 24'hC00000;
    test_reset();
    test_fetch_load();
    test_stall();
    test_timeout();
    test_illegal();
    test_halt();
    test_end_sel();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
